// File: rtl/stm32_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : stm32_bus_master
//  Description : Initiator for the 8-bit parallel STM32<->FPGA bus. Issues one
//                command per transaction (DATA_SYNC cycle carrying the code,
//                then byte phases), drives write payloads and captures read
//                payloads. All outputs and the bus drive are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module stm32_bus_master #(
    parameter int         GAP_CYCLES   = 1,
    parameter logic [7:0] TEST_PATTERN = 8'hA5
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_code,
    input  logic [31:0] wr_data,
    output logic [63:0] rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        err,
    output logic        bus_test_ok,
    output logic        busy,
    output logic        DATA_SYNC,
    inout  wire  [7:0]  DATA_BUS
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SYNC     = 3'd1,
        S_WRITE    = 3'd2,
        S_READ     = 3'd3,
        S_TEST_DRV = 3'd4,
        S_TEST_CAP = 3'd5,
        S_GAP      = 3'd6
    } state_t;

    // The gap counter counts down to zero, so it is loaded with one less.
    localparam logic [3:0] c_gap_load = 4'(GAP_CYCLES - 1);

    state_t      r_state,   w_state_nxt;
    logic [3:0]  r_cnt,     w_cnt_nxt;
    logic [3:0]  r_gap,     w_gap_nxt;
    logic [2:0]  r_code,    w_code_nxt;
    logic [31:0] r_wdata,   w_wdata_nxt;
    logic [63:0] r_shift,   w_shift_nxt;
    logic [63:0] r_rd_data, w_rd_data_nxt;
    logic [7:0]  r_bus_dout, w_dout_nxt;
    logic        r_bus_oe,  w_oe_nxt;
    logic        r_sync,    w_sync_nxt;
    logic        r_ready,   w_ready_nxt;
    logic        r_done,    w_done_nxt;
    logic        r_rd_valid, w_rdv_nxt;
    logic        r_err,     w_err_nxt;
    logic        r_test_ok, w_ok_nxt;
    logic        w_accept;
    logic [3:0]  w_rd_len;
    logic        w_echo_ok;

    assign w_accept  = cmd_valid && r_ready;
    // RX IQ returns 8 bytes, SEND PARAMS returns 5.
    assign w_rd_len  = (r_code == 3'd4) ? 4'd8 : 4'd5;
    assign w_echo_ok = (DATA_BUS == TEST_PATTERN);

    // Next-state and next-output logic; every output is loaded one cycle
    // ahead so that the visible value is a flop output.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_gap_nxt     = (r_state == S_GAP) ? (r_gap - 4'd1) : c_gap_load;
        w_code_nxt    = r_code;
        w_wdata_nxt   = r_wdata;
        w_shift_nxt   = r_shift;
        w_rd_data_nxt = r_rd_data;
        w_dout_nxt    = r_bus_dout;
        w_oe_nxt      = 1'b0;
        w_sync_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_rdv_nxt     = 1'b0;
        w_err_nxt     = 1'b0;
        w_ok_nxt      = r_test_ok;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_code_nxt  = cmd_code;
                    w_wdata_nxt = wr_data;
                    w_shift_nxt = '0;
                    if (cmd_code == 3'd7) begin
                        // Unsupported code never touches the bus.
                        w_state_nxt = S_GAP;
                        w_done_nxt  = 1'b1;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_SYNC;
                        w_sync_nxt  = 1'b1;
                        w_oe_nxt    = 1'b1;
                        w_dout_nxt  = {5'b0, cmd_code};
                    end
                end
            end

            S_SYNC: begin
                w_cnt_nxt = 4'd0;
                case (r_code)
                    3'd1, 3'd3: begin
                        w_state_nxt = S_WRITE;
                        w_oe_nxt    = 1'b1;
                        w_dout_nxt  = r_wdata[31:24];
                        w_wdata_nxt = {r_wdata[23:0], 8'h00};
                    end
                    3'd2, 3'd4: begin
                        w_state_nxt = S_READ;
                    end
                    3'd0: begin
                        w_state_nxt = S_TEST_DRV;
                        w_oe_nxt    = 1'b1;
                        w_dout_nxt  = TEST_PATTERN;
                    end
                    default: begin
                        w_state_nxt = S_GAP;
                        w_done_nxt  = 1'b1;
                    end
                endcase
            end

            S_WRITE: begin
                if (r_cnt == 4'd3) begin
                    w_state_nxt = S_GAP;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + 4'd1;
                    w_oe_nxt    = 1'b1;
                    w_dout_nxt  = r_wdata[31:24];
                    w_wdata_nxt = {r_wdata[23:0], 8'h00};
                end
            end

            S_READ: begin
                // Count 0 is the turnaround cycle; counts 1..N carry bytes.
                if (r_cnt != 4'd0) begin
                    w_shift_nxt = {r_shift[55:0], DATA_BUS};
                end
                if (r_cnt == w_rd_len) begin
                    w_state_nxt   = S_GAP;
                    w_done_nxt    = 1'b1;
                    w_rdv_nxt     = 1'b1;
                    w_rd_data_nxt = w_shift_nxt;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end

            S_TEST_DRV: begin
                w_state_nxt = S_TEST_CAP;
            end

            S_TEST_CAP: begin
                w_state_nxt = S_GAP;
                w_done_nxt  = 1'b1;
                w_ok_nxt    = w_echo_ok;
                w_err_nxt   = !w_echo_ok;
            end

            S_GAP: begin
                if (r_gap == 4'd0) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_ready_nxt = (w_state_nxt == S_IDLE);
    end

    // State, counters, payload and output registers; reset drops any
    // in-flight transaction without a done pulse.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_gap      <= 4'd0;
            r_code     <= 3'd0;
            r_wdata    <= '0;
            r_shift    <= '0;
            r_rd_data  <= '0;
            r_bus_dout <= 8'h00;
            r_bus_oe   <= 1'b0;
            r_sync     <= 1'b0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
            r_test_ok  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_gap      <= w_gap_nxt;
            r_code     <= w_code_nxt;
            r_wdata    <= w_wdata_nxt;
            r_shift    <= w_shift_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_bus_dout <= w_dout_nxt;
            r_bus_oe   <= w_oe_nxt;
            r_sync     <= w_sync_nxt;
            r_ready    <= w_ready_nxt;
            r_done     <= w_done_nxt;
            r_rd_valid <= w_rdv_nxt;
            r_err      <= w_err_nxt;
            r_test_ok  <= w_ok_nxt;
        end
    end

    assign DATA_BUS    = r_bus_oe ? r_bus_dout : 8'bz;
    assign DATA_SYNC   = r_sync;
    assign cmd_ready   = r_ready;
    assign busy        = !r_ready;
    assign done        = r_done;
    assign rd_valid    = r_rd_valid;
    assign err         = r_err;
    assign bus_test_ok = r_test_ok;
    assign rd_data     = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_stm32_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stm32_bus_master
//  Description : Self-checking bench for stm32_bus_master with a cycle-level
//                responder and a timeline model of each command.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stm32_bus_master;

    localparam int         G   = 3;
    localparam logic [7:0] PAT = 8'hA5;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_code;
    logic [31:0] wr_data;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        err;
    logic        bus_test_ok;
    logic        busy;
    logic        DATA_SYNC;
    wire  [7:0]  DATA_BUS;

    logic        tb_oe;
    logic [7:0]  tb_drv;
    assign DATA_BUS = tb_oe ? tb_drv : 8'bz;

    int n_pass;
    int n_total;

    // Model of the held outputs between commands.
    logic [63:0] m_rd;
    logic        m_ok;

    typedef struct {
        logic [2:0]  code;
        logic [31:0] wdata;
        logic [63:0] resp;
        logic [7:0]  echo;
        logic [63:0] exp_rd;
        logic        exp_ok;
        logic        exp_err;
    } vec_t;

    vec_t vecs [8];

    stm32_bus_master #(
        .GAP_CYCLES   (G),
        .TEST_PATTERN (PAT)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_code    (cmd_code),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .done        (done),
        .err         (err),
        .bus_test_ok (bus_test_ok),
        .busy        (busy),
        .DATA_SYNC   (DATA_SYNC),
        .DATA_BUS    (DATA_BUS)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Cycle (counted from the cycle after accept) in which done pulses.
    function automatic int done_cycle(input logic [2:0] code);
        case (code)
            3'd0:       return 3;
            3'd1, 3'd3: return 5;
            3'd2:       return 7;
            3'd4:       return 10;
            3'd5, 3'd6: return 1;
            default:    return 0;
        endcase
    endfunction

    function automatic logic exp_oe(input logic [2:0] code, input int c);
        if (code == 3'd7) return 1'b0;
        if (c == 0) return 1'b1;
        if (code == 3'd1 || code == 3'd3) return (c >= 1 && c <= 4);
        if (code == 3'd0) return (c == 1);
        return 1'b0;
    endfunction

    function automatic logic [7:0] exp_byte(input logic [2:0] code, input logic [31:0] wdata, input int c);
        if (c == 0) return {5'b0, code};
        if (code == 3'd0) return PAT;
        return 8'(wdata >> (8 * (4 - c)));
    endfunction

    // Responder: byte i of a read in cycle i+2, bus-test echo in cycle 2.
    task automatic set_resp(input logic [2:0] code, input logic [63:0] resp, input logic [7:0] echo, input int c);
        int n;
        tb_oe = 1'b0;
        n = (code == 3'd4) ? 8 : 5;
        if ((code == 3'd2 || code == 3'd4) && c >= 2 && (c - 2) < n) begin
            tb_oe  = 1'b1;
            tb_drv = 8'(resp >> (8 * (7 - (c - 2))));
        end
        if (code == 3'd0 && c == 2) begin
            tb_oe  = 1'b1;
            tb_drv = echo;
        end
    endtask

    // Issue one command and check every cycle through the return to IDLE.
    // Entered and left at a falling edge.
    task automatic run_cmd(input logic [2:0] code, input logic [31:0] wdata, input logic [63:0] resp,
                           input logic [7:0] echo, input bit hold, input logic [2:0] next_code,
                           output logic err_seen);
        int          d;
        int          waited;
        logic [63:0] e_rd;
        logic        e_ok;
        logic        e_err;
        d      = done_cycle(code);
        waited = 0;
        while (!cmd_ready && waited < 64) begin
            @(negedge clk_in);
            waited++;
        end
        if (!cmd_ready) chk("ready_wait", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_code  = code;
        wr_data   = wdata;
        @(posedge clk_in);
        #1;
        cmd_valid = hold;
        cmd_code  = hold ? next_code : 3'($urandom);
        wr_data   = $urandom;

        e_rd  = (code == 3'd4) ? resp : (code == 3'd2) ? (resp >> 24) : m_rd;
        e_ok  = (code == 3'd0) ? (echo == PAT) : m_ok;
        e_err = (code == 3'd7) || (code == 3'd0 && echo != PAT);
        err_seen = 1'b0;

        for (int c = 0; c <= d + G; c++) begin
            set_resp(code, resp, echo, c);
            @(negedge clk_in);
            chk("sync", DATA_SYNC, (code != 3'd7 && c == 0));
            chk("bus_oe", dut.r_bus_oe, exp_oe(code, c));
            if (exp_oe(code, c)) chk("bus_byte", DATA_BUS, exp_byte(code, wdata, c));
            chk("done", done, (c == d));
            chk("rd_valid", rd_valid, (c == d && (code == 3'd2 || code == 3'd4)));
            chk("err", err, (c == d && e_err));
            chk("cmd_ready", cmd_ready, (c >= d + G));
            chk("busy", busy, (c < d + G));
            chk("rd_data", rd_data, (c >= d) ? e_rd : m_rd);
            chk("bus_test_ok", bus_test_ok, (c >= d) ? e_ok : m_ok);
            if (c == d) err_seen = err;
            if (c != d + G) begin
                @(posedge clk_in);
                #1;
            end
        end
        tb_oe = 1'b0;
        m_rd  = e_rd;
        m_ok  = e_ok;
    endtask

    initial begin
        logic        e;
        logic [2:0]  cur;
        logic [2:0]  nxt;
        bit          hold;
        logic [63:0] resp;
        logic [7:0]  echo;

        n_pass    = 0;
        n_total   = 0;
        m_rd      = '0;
        m_ok      = 1'b0;
        rst_in    = 1'b1;
        cmd_valid = 1'b0;
        cmd_code  = 3'd0;
        wr_data   = '0;
        tb_oe     = 1'b0;
        tb_drv    = 8'h00;

        vecs[0] = '{3'd0, 32'h0,          64'h0,                  8'hA5, 64'h0,                  1'b1, 1'b0};
        vecs[1] = '{3'd1, 32'h0C097777,   64'h0,                  8'h00, 64'h0,                  1'b1, 1'b0};
        vecs[2] = '{3'd4, 32'h0,          64'h1122334455667788,   8'h00, 64'h1122334455667788,   1'b1, 1'b0};
        vecs[3] = '{3'd2, 32'h0,          64'h3FABCDEF1299AABB,   8'h00, 64'h0000003FABCDEF12,   1'b1, 1'b0};
        vecs[4] = '{3'd0, 32'h0,          64'h0,                  8'hA4, 64'h0000003FABCDEF12,   1'b0, 1'b1};
        vecs[5] = '{3'd3, 32'hDEADBEEF,   64'h0,                  8'h00, 64'h0000003FABCDEF12,   1'b0, 1'b0};
        vecs[6] = '{3'd6, 32'h0,          64'h0,                  8'h00, 64'h0000003FABCDEF12,   1'b0, 1'b0};
        vecs[7] = '{3'd0, 32'h0,          64'h0,                  8'hA5, 64'h0000003FABCDEF12,   1'b1, 1'b0};

        // Reset state.
        repeat (2) @(negedge clk_in);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sync", DATA_SYNC, 1'b0);
        chk("rst_oe", dut.r_bus_oe, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rdv", rd_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_ok", bus_test_ok, 1'b0);
        chk("rst_rd", rd_data, 64'h0);
        rst_in = 1'b0;
        @(negedge clk_in);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].code, vecs[i].wdata, vecs[i].resp, vecs[i].echo, 1'b0, 3'd0, e);
            chk("vec_rd", rd_data, vecs[i].exp_rd);
            chk("vec_ok", bus_test_ok, vecs[i].exp_ok);
            chk("vec_err", e, vecs[i].exp_err);
        end

        // Reset in cycle 5 of an RX IQ.
        cmd_valid = 1'b1;
        cmd_code  = 3'd4;
        @(posedge clk_in);
        #1;
        cmd_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            set_resp(3'd4, 64'hCAFEF00D12345678, 8'h00, c);
            @(posedge clk_in);
            #1;
        end
        tb_oe  = 1'b0;
        rst_in = 1'b1;
        #1;
        chk("mid_rst_sync", DATA_SYNC, 1'b0);
        chk("mid_rst_oe", dut.r_bus_oe, 1'b0);
        chk("mid_rst_ready", cmd_ready, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_rd", rd_data, 64'h0);
        chk("mid_rst_ok", bus_test_ok, 1'b0);
        @(negedge clk_in);
        rst_in = 1'b0;
        m_rd   = '0;
        m_ok   = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_in);
            chk("post_rst_done", done, 1'b0);
            chk("post_rst_ready", cmd_ready, 1'b1);
        end

        // Code 7 then code 5 with cmd_valid held across the gap.
        run_cmd(3'd7, 32'h0, 64'h0, 8'h00, 1'b1, 3'd5, e);
        chk("code7_err", e, 1'b1);
        run_cmd(3'd5, 32'h0, 64'h0, 8'h00, 1'b0, 3'd0, e);
        chk("code5_err", e, 1'b0);

        // Randomized commands against the timeline model.
        cur = 3'($urandom_range(0, 7));
        for (int i = 0; i < 40; i++) begin
            nxt  = 3'($urandom_range(0, 7));
            hold = bit'($urandom_range(0, 1));
            resp = {$urandom, $urandom};
            echo = ($urandom_range(0, 1) == 1) ? PAT : 8'($urandom);
            run_cmd(cur, $urandom, resp, echo, hold, nxt, e);
            cur = nxt;
        end
        cmd_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
